// File: rtl/fc_layer_controller.sv
// Sequences one image through the FC datapath (FILL, COLLECT, FLUSH) and keeps a running argmax of the class scores. FC_SCORE_TAP_EN adds a score echo port.
// Latency: decision_valid follows the final score capture by 1 cycle. The image period is INPUT_WIDTH beats + 2*OUTPUT_NUM-1 + 1 cycles.
// Backpressure: ready_out is high only in FILL; beats offered in COLLECT/FLUSH are ignored.
module fc_layer_controller #(
    parameter int INPUT_WIDTH = 16,
    parameter int OUTPUT_NUM  = 10,
    parameter int DATA_BITS   = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic                        fc_valid_in,
    output logic                        fc_rst_n,
    input  logic signed [DATA_BITS-1:0] fc_data_out,
    input  logic                        fc_valid_out,
    output logic [3:0]                  decision,
    output logic signed [DATA_BITS-1:0] max_score,
    output logic                        decision_valid
`ifdef FC_SCORE_TAP_EN
    ,
    output logic signed [DATA_BITS-1:0] score_tap,
    output logic [3:0]                  score_tap_idx,
    output logic                        score_tap_valid
`endif
);

    localparam int BW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    localparam logic [1:0] S_FILL    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(INPUT_WIDTH - 1);
    localparam logic [3:0]    LAST_CLASS = 4'(OUTPUT_NUM - 1);

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic [BW-1:0]               beat_cnt;
    logic [3:0]                  score_idx;
    logic                        ready_q;
    logic                        drive_q;
    logic                        fc_rst_q;
    logic                        decision_valid_q;
    logic signed [DATA_BITS-1:0] max_q;
    logic [3:0]                  max_idx_q;

    logic                        beat;
    logic                        capture;
    logic                        last_capture;
    logic                        take_new;
    logic signed [DATA_BITS-1:0] best_score;
    logic [3:0]                  best_idx;

    assign beat         = (state_q == S_FILL) && ready_q && valid_in;
    assign capture      = (state_q == S_COLLECT) && fc_valid_out;
    assign last_capture = capture && (score_idx == LAST_CLASS);

    // Strict greater-than keeps the lowest index on ties; class 0 always seeds.
    assign take_new   = (score_idx == 4'd0) || (fc_data_out > max_q);
    assign best_score = take_new ? fc_data_out : max_q;
    assign best_idx   = take_new ? score_idx : max_idx_q;

    assign ready_out      = ready_q;
    assign fc_valid_in    = beat || drive_q;
    assign fc_rst_n       = fc_rst_q;
    assign decision_valid = decision_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:    if (beat && (beat_cnt == LAST_BEAT)) state_d = S_COLLECT;
            S_COLLECT: if (last_capture) state_d = S_FLUSH;
            S_FLUSH:   state_d = S_FILL;
            default:   state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_FILL;
            beat_cnt         <= '0;
            score_idx        <= 4'd0;
            ready_q          <= 1'b0;
            drive_q          <= 1'b0;
            fc_rst_q         <= 1'b0;
            decision_valid_q <= 1'b0;
            max_q            <= '0;
            max_idx_q        <= 4'd0;
            decision         <= 4'd0;
            max_score        <= '0;
        end else begin
            state_q          <= state_d;
            ready_q          <= (state_d == S_FILL);
            fc_rst_q         <= (state_d != S_FLUSH);
            // The final class gets no drive pulse so the FC output index never wraps.
            drive_q          <= capture && !last_capture;
            decision_valid_q <= last_capture;

            if (beat) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end

            if (capture) begin
                score_idx <= score_idx + 4'd1;
                max_q     <= best_score;
                max_idx_q <= best_idx;
            end else if (state_q == S_FLUSH) begin
                score_idx <= 4'd0;
            end

            if (last_capture) begin
                decision  <= best_idx;
                max_score <= best_score;
            end
        end
    end

`ifdef FC_SCORE_TAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_tap       <= '0;
            score_tap_idx   <= 4'd0;
            score_tap_valid <= 1'b0;
        end else begin
            score_tap_valid <= capture;
            if (capture) begin
                score_tap     <= fc_data_out;
                score_tap_idx <= score_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_controller.sv
// Directed bench for fc_layer_controller with a behavioural FC datapath model.
module tb_fc_layer_controller;

    localparam int IW = 16;
    localparam int ON = 10;
    localparam int DB = 12;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b1;
    logic                 valid_in = 1'b0;
    logic                 ready_out;
    logic                 fc_valid_in;
    logic                 fc_rst_n;
    logic signed [DB-1:0] fc_data_out  = '0;
    logic                 fc_valid_out = 1'b0;
    logic [3:0]           decision;
    logic signed [DB-1:0] max_score;
    logic                 decision_valid;
`ifdef FC_SCORE_TAP_EN
    logic signed [DB-1:0] score_tap;
    logic [3:0]           score_tap_idx;
    logic                 score_tap_valid;
`endif

    fc_layer_controller #(.INPUT_WIDTH(IW), .OUTPUT_NUM(ON), .DATA_BITS(DB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .fc_valid_in    (fc_valid_in),
        .fc_rst_n       (fc_rst_n),
        .fc_data_out    (fc_data_out),
        .fc_valid_out   (fc_valid_out),
        .decision       (decision),
        .max_score      (max_score),
        .decision_valid (decision_valid)
`ifdef FC_SCORE_TAP_EN
        ,
        .score_tap      (score_tap),
        .score_tap_idx  (score_tap_idx),
        .score_tap_valid(score_tap_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ON-1:0][DB-1:0] sc;
        bit                    gaps;
        bit                    hold;
        int                    exp_dec;
        int                    exp_max;
    } vec_t;

    vec_t vec[7];

    int passed = 0;
    int total  = 0;

    int cyc = 0;
    int fill_fv, mirror_err, drive_cnt, spacing_err, last_drive;
    int cap_cnt, dv_cnt, rstlow_cnt, tap_exp;
    int prev_dec = 0;
    int prev_max = 0;

    logic signed [DB-1:0] m_sc [ON];
    int m_beats = 0;
    int m_idx   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [ON-1:0][DB-1:0] s10(input int a0, input int a1, input int a2,
            input int a3, input int a4, input int a5, input int a6, input int a7,
            input int a8, input int a9);
        logic [ON-1:0][DB-1:0] r;
        r[0] = DB'(a0); r[1] = DB'(a1); r[2] = DB'(a2); r[3] = DB'(a3); r[4] = DB'(a4);
        r[5] = DB'(a5); r[6] = DB'(a6); r[7] = DB'(a7); r[8] = DB'(a8); r[9] = DB'(a9);
        return r;
    endfunction

    task automatic clr();
        fill_fv = 0; mirror_err = 0; drive_cnt = 0; spacing_err = 0; last_drive = -1;
        cap_cnt = 0; dv_cnt = 0; rstlow_cnt = 0; tap_exp = 0;
    endtask

    // FC datapath model: class 0 one cycle after the last fill beat, then one score per drive pulse.
    always @(posedge clk) begin
        if (!fc_rst_n) begin
            m_beats = 0;
            m_idx   = 0;
            fc_valid_out <= 1'b0;
        end else begin
            fc_valid_out <= 1'b0;
            if (fc_valid_in) begin
                if (m_beats < IW) begin
                    m_beats++;
                    if (m_beats == IW) begin
                        fc_valid_out <= 1'b1;
                        fc_data_out  <= m_sc[0];
                        m_idx = 1;
                    end
                end else if (m_idx < ON) begin
                    fc_valid_out <= 1'b1;
                    fc_data_out  <= m_sc[m_idx];
                    m_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ready_out) begin
                if (fc_valid_in) fill_fv++;
                if (fc_valid_in != valid_in) mirror_err++;
            end else if (fc_valid_in) begin
                drive_cnt++;
                if (last_drive >= 0 && cyc - last_drive != 2) spacing_err++;
                last_drive = cyc;
            end
            if (!ready_out && fc_valid_out) cap_cnt++;
            if (decision_valid) dv_cnt++;
            if (!fc_rst_n) rstlow_cnt++;
`ifdef FC_SCORE_TAP_EN
            if (score_tap_valid) begin
                chk("tap_idx", int'(score_tap_idx), tap_exp);
                chk("tap_val", int'(score_tap), int'(m_sc[score_tap_idx]));
                tap_exp++;
            end
`endif
        end
    end

    task automatic send_beats(input int i);
        for (int b = 0; b < IW; b++) begin
            if (vec[i].gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    valid_in = 1'b0;
                    @(posedge clk); #1;
                end
            end
            valid_in = 1'b1;
            @(posedge clk); #1;
            if (b == 0) begin
                chk($sformatf("v%0d_dec_held", i), int'(decision), prev_dec);
                chk($sformatf("v%0d_max_held", i), int'(max_score), prev_max);
            end
        end
        if (!vec[i].hold) valid_in = 1'b0;
        chk($sformatf("v%0d_ready_after_fill", i), int'(ready_out), 0);
    endtask

    task automatic run_image(input int i);
        int got;
        for (int k = 0; k < ON; k++) m_sc[k] = vec[i].sc[k];
        clr();
        send_beats(i);
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (decision_valid) begin
                got = 1;
                break;
            end
        end
        chk($sformatf("v%0d_dv_seen", i), got, 1);
        chk($sformatf("v%0d_decision", i), int'(decision), vec[i].exp_dec);
        chk($sformatf("v%0d_max_score", i), int'(max_score), vec[i].exp_max);
        chk($sformatf("v%0d_fc_rst_n_flush", i), int'(fc_rst_n), 0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk($sformatf("v%0d_ready_after_flush", i), int'(ready_out), 1);
        chk($sformatf("v%0d_fc_rst_n_after", i), int'(fc_rst_n), 1);
        repeat (2) begin @(posedge clk); #1; end
        chk($sformatf("v%0d_dv_pulses", i), dv_cnt, 1);
        chk($sformatf("v%0d_drive_pulses", i), drive_cnt, ON - 1);
        chk($sformatf("v%0d_drive_spacing_err", i), spacing_err, 0);
        chk($sformatf("v%0d_rst_low_cycles", i), rstlow_cnt, 1);
        chk($sformatf("v%0d_fill_beats", i), fill_fv, IW);
        chk($sformatf("v%0d_mirror_err", i), mirror_err, 0);
`ifdef FC_SCORE_TAP_EN
        chk($sformatf("v%0d_tap_pulses", i), tap_exp, ON);
`endif
        prev_dec = vec[i].exp_dec;
        prev_max = vec[i].exp_max;
    endtask

    initial begin
        int got;
        vec[0] = '{s10(5, 9, -3, 9, 0, 1, 2, 3, 4, -8), 1'b0, 1'b0, 1, 9};
        vec[1] = '{s10(3, -1, 7, 2, 7, 0, -5, 6, 1, 4), 1'b1, 1'b0, 2, 7};
        vec[2] = '{s10(-100, -100, -100, -100, -100, -100, -100, -100, -100, -100), 1'b0, 1'b0, 0, -100};
        vec[3] = '{s10(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b1, 8, 1};
        vec[4] = '{s10(0, 1, 2, 3, 4, 5, 6, 7, 8, 2047), 1'b0, 1'b0, 9, 2047};
        vec[5] = '{s10(-2048, -2048, -2048, -2048, -2048, -2047, -2048, -2048, -2048, -2048), 1'b1, 1'b0, 5, -2047};
        vec[6] = '{s10(7, -1, -1, 6, -1, -1, -1, -1, -1, 7), 1'b0, 1'b1, 0, 7};
        clr();

        rst_n    = 1'b0;
        valid_in = 1'b1;
        #12;
        chk("rst_ready_out", int'(ready_out), 0);
        chk("rst_fc_valid_in", int'(fc_valid_in), 0);
        chk("rst_fc_rst_n", int'(fc_rst_n), 0);
        chk("rst_decision", int'(decision), 0);
        chk("rst_max_score", int'(max_score), 0);
        chk("rst_decision_valid", int'(decision_valid), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_fc_rst_n", int'(fc_rst_n), 1);
        chk("post_rst_ready_out", int'(ready_out), 1);

        for (int i = 0; i < 7; i++) run_image(i);

        // Abandon an image after four captures.
        for (int k = 0; k < ON; k++) m_sc[k] = vec[0].sc[k];
        clr();
        send_beats(0);
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (cap_cnt >= 4) begin
                got = 1;
                break;
            end
        end
        chk("abort_four_captures", got, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_fc_rst_n", int'(fc_rst_n), 0);
        chk("abort_ready_out", int'(ready_out), 0);
        chk("abort_fc_valid_in", int'(fc_valid_in), 0);
        chk("abort_decision", int'(decision), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_fc_rst_n_held", int'(fc_rst_n), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_dv_pulses", dv_cnt, 0);
        chk("abort_release_fc_rst_n", int'(fc_rst_n), 1);
        chk("abort_release_ready", int'(ready_out), 1);
        prev_dec = 0;
        prev_max = 0;
        run_image(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
